// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply/divide unit that owns the HI/LO
// register pair. Multiply is shift-add over WIDTH cycles, divide is restoring
// over WIDTH cycles, followed by one sign-correction cycle before HI/LO commit.
module muldiv_sequencer #(
   parameter int         WIDTH  = 32,
   parameter logic [2:0] OP_MUL = 3'd5,
   parameter logic [2:0] OP_DIV = 3'd7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             hilo_read,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_FIXUP = 2'd3;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   // MUL: {partial product, remaining multiplier bits}; DIV: low half is the
   // dividend shifting out on the left while quotient bits shift in on the right.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH:0]     r_rem;      // restoring-divide partial remainder
   logic [WIDTH-1:0]   r_opb;      // |multiplicand| for MUL, |divisor| for DIV
   logic               r_is_div;
   logic               r_neg_q;    // product / quotient must be negated
   logic               r_neg_r;    // remainder takes the dividend's sign
   logic               r_dz_pend;  // divisor was zero for the op in flight
   logic               r_done;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_accept;
   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_remv;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   // Request decode and operand magnitudes (most-negative maps to 2^(W-1) unsigned).
   always_comb begin
      w_accept = start && (r_state == ST_IDLE) && ((op == OP_MUL) || (op == OP_DIV));
      w_abs1   = in1[WIDTH-1] ? -in1 : in1;
      w_abs2   = in2[WIDTH-1] ? -in2 : in2;
   end

   // One iteration of the shift-add multiply and of the restoring divide.
   always_comb begin
      w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
      w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_opb};
   end

   // Sign correction applied in FIXUP; divide-by-zero forces an all-ones quotient.
   always_comb begin
      w_prod = r_neg_q ? -r_acc : r_acc;
      w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_remv = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      if (r_is_div) begin
         w_fix_hi = w_remv;
         w_fix_lo = r_dz_pend ? {WIDTH{1'b1}} : w_quot;
      end else begin
         w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod[WIDTH-1:0];
      end
   end

   // Sequencer: accept, iterate WIDTH steps, correct signs, commit HI/LO.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_rem      <= '0;
         r_opb      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz_pend  <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt      <= '0;
                  r_rem      <= '0;
                  r_div_zero <= 1'b0;
                  r_neg_q    <= in1[WIDTH-1] ^ in2[WIDTH-1];
                  r_neg_r    <= in1[WIDTH-1];
                  if (op == OP_DIV) begin
                     r_is_div  <= 1'b1;
                     r_dz_pend <= (in2 == '0);
                     r_opb     <= w_abs2;
                     r_acc     <= {{WIDTH{1'b0}}, w_abs1};
                     r_state   <= ST_DIV;
                  end else begin
                     r_is_div  <= 1'b0;
                     r_dz_pend <= 1'b0;
                     r_opb     <= w_abs1;
                     r_acc     <= {{WIDTH{1'b0}}, w_abs2};
                     r_state   <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               r_acc <= {w_sum, r_acc[WIDTH-1:1]};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) begin
                  r_state <= ST_FIXUP;
               end
            end
            ST_DIV: begin
               if (!w_diff[WIDTH]) begin
                  r_rem            <= w_diff;
                  r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem            <= w_shift;
                  r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) begin
                  r_state <= ST_FIXUP;
               end
            end
            default: begin
               r_hi       <= w_fix_hi;
               r_lo       <= w_fix_lo;
               r_done     <= 1'b1;
               r_div_zero <= r_dz_pend;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign stall    = hilo_read & busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven directed checks of the multiply/divide
// sequencer plus hand-written sequences for ignored starts, reset abort and
// back-to-back issue.
module tb_muldiv_sequencer;

   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd7;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op    = 3'd0;
   logic [31:0] in1   = '0;
   logic [31:0] in2   = '0;
   logic        hilo_read = 1'b0;
   logic        busy, stall, done, div_zero;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_sequencer #(.WIDTH(32), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .in1      (in1),
      .in2      (in2),
      .hilo_read(hilo_read),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        edz;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; issues start there and returns at the first negedge
   // with busy low (the done cycle), or after a 100-cycle bound.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int bcnt, output logic first_busy,
                        output logic hold_ok, output logic stall_ok);
      logic [31:0] prev_hi, prev_lo;
      prev_hi = hi;
      prev_lo = lo;
      start = 1'b1; op = o; in1 = a; in2 = b;
      @(negedge clock);
      start = 1'b0; op = 3'd0;
      first_busy = busy;
      bcnt = 0; hold_ok = 1'b1; stall_ok = 1'b1;
      while (busy && bcnt < 100) begin
         if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
         if (stall !== hilo_read) stall_ok = 1'b0;
         if (bcnt == inject) begin
            start = 1'b1; op = OP_DIV; in1 = 32'd9; in2 = 32'd3;
         end else begin
            start = 1'b0; op = 3'd0;
         end
         bcnt++;
         @(negedge clock);
      end
      start = 1'b0; op = 3'd0;
      $display("op=%0d in1=%h in2=%h -> hi=%h lo=%h div_zero=%0d busy_cycles=%0d",
               o, a, b, hi, lo, div_zero, bcnt);
   endtask

   initial begin
      int          bcnt;
      logic        fb, hold_ok, stall_ok;
      logic [31:0] sv_hi, sv_lo;

      vecs[0]  = '{OP_MUL, 32'h3AAA1111, 32'h00002000, 32'h00000755, 32'h42222000, 1'b0};
      vecs[1]  = '{OP_DIV, 32'hFFFFFF9B, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFDF, 1'b0};
      vecs[2]  = '{OP_DIV, 32'h00000065, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFDF, 1'b0};
      vecs[3]  = '{OP_DIV, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{OP_MUL, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      vecs[5]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{OP_MUL, 32'hFFFFFFF9, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
      vecs[8]  = '{OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vecs[9]  = '{OP_DIV, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{OP_DIV, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);

      // Table of directed operations, MFHI/MFLO pending throughout
      hilo_read = 1'b1;
      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, bcnt, fb, hold_ok, stall_ok);
         chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd33);
         chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
         chk($sformatf("v%0d_stall_in_done", i), 64'(stall), 64'd0);
         chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
         chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
         chk($sformatf("v%0d_div_zero", i), 64'(div_zero), 64'(vecs[i].edz));
         chk($sformatf("v%0d_hilo_hold", i), 64'(hold_ok), 64'd1);
         chk($sformatf("v%0d_stall_eq_busy", i), 64'(stall_ok), 64'd1);
      end
      hilo_read = 1'b0;

      // done is a single-cycle pulse
      @(negedge clock);
      chk("done_pulse_width", 64'(done), 64'd0);

      // start with a non-mul/div op is ignored
      sv_hi = hi; sv_lo = lo;
      start = 1'b1; op = 3'd2; in1 = 32'd4; in2 = 32'd4;
      @(negedge clock);
      start = 1'b0; op = 3'd0;
      chk("other_op_busy", 64'(busy), 64'd0);
      @(negedge clock);
      chk("other_op_hi", 64'(hi), 64'(sv_hi));
      chk("other_op_lo", 64'(lo), 64'(sv_lo));
      $display("op=2 in1=00000004 in2=00000004 -> ignored busy=%0d", busy);

      // DIV start injected mid-MULT must not disturb it; stall stays low without hilo_read
      do_op(OP_MUL, 32'd100, 32'hFFFFFFFD, 5, bcnt, fb, hold_ok, stall_ok);
      chk("inject_busy_cycles", 64'(bcnt), 64'd33);
      chk("inject_hi", 64'(hi), 64'hFFFFFFFF);
      chk("inject_lo", 64'(lo), 64'hFFFFFED4);
      chk("inject_stall_low", 64'(stall_ok), 64'd1);

      // Back-to-back: start issued in the done cycle
      chk("b2b_done_cycle", 64'(done), 64'd1);
      do_op(OP_MUL, 32'd2, 32'd3, -1, bcnt, fb, hold_ok, stall_ok);
      chk("b2b_first_busy", 64'(fb), 64'd1);
      chk("b2b_busy_cycles", 64'(bcnt), 64'd33);
      chk("b2b_lo", 64'(lo), 64'd6);
      chk("b2b_hi", 64'(hi), 64'd0);

      // Reset at cycle 10 of a DIV aborts without commit
      start = 1'b1; op = OP_DIV; in1 = 32'd100; in2 = 32'd7;
      @(negedge clock);
      start = 1'b0; op = 3'd0;
      repeat (9) @(negedge clock);
      chk("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      repeat (40) @(negedge clock);
      chk("abort_no_commit_done", 64'(done), 64'd0);
      chk("abort_no_commit_lo", 64'(lo), 64'd0);
      $display("op=7 in1=00000064 in2=00000007 -> reset abort hi=%h lo=%h busy=%0d", hi, lo, busy);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
